// File: rtl/sr_flag_scheduler.sv
// sr_flag_scheduler: round-robin arbitrated SR flag bank with clear-all sweep; define SR_SCHED_ERR_EN for sticky err
module sr_flag_scheduler #(
  parameter int N_REQ = 4,
  parameter int NUM_FLAGS = 8,
  localparam int IDX_W = $clog2(NUM_FLAGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       req_s,
  input  logic [N_REQ-1:0]       req_r,
  input  logic [N_REQ*IDX_W-1:0] req_idx,
  output logic [N_REQ-1:0]       gnt,
  input  logic                   sweep_start,
  output logic                   sweep_busy,
  output logic                   sweep_done,
  output logic [NUM_FLAGS-1:0]   flags,
  output logic                   err
);
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state;
  logic [PW-1:0] ptr, gk;
  logic [IDX_W-1:0] cnt, cix;
  logic hit, arb_en, cs, cr, in_range;
  assign arb_en = reset && state == IDLE && !sweep_start;
  always_comb begin
    hit = 1'b0;
    gk = '0;
    for (int j = N_REQ - 1; j >= 0; j--)
      if (arb_en && req[(int'(ptr) + j) % N_REQ]) begin
        hit = 1'b1;
        gk = PW'((int'(ptr) + j) % N_REQ);
      end
  end
  assign gnt = hit ? (N_REQ'(1) << gk) : '0;
  assign cs = req_s[gk];
  assign cr = req_r[gk];
  assign cix = req_idx[int'(gk)*IDX_W +: IDX_W];
  assign in_range = 32'(cix) < NUM_FLAGS;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      flags <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sweep_start) begin
            state <= SWEEP;
            cnt <= '0;
            sweep_busy <= 1'b1;
          end else if (hit) begin
            ptr <= (gk == PW'(N_REQ - 1)) ? '0 : gk + 1'b1;
            if (in_range && (cs ^ cr)) flags[cix] <= cs;
          end
        end
        SWEEP: begin
          flags[cnt] <= 1'b0;
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(NUM_FLAGS - 1)) begin
            state <= DONE;
            sweep_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          sweep_done <= 1'b0;
          sweep_busy <= 1'b0;
        end
      endcase
    end
  end
`ifdef SR_SCHED_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else if (hit && ((cs && cr) || !in_range)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule
